mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage of the MIPS150 pipeline, directly downstream of the execute-stage ALU.
- Takes the ALU result, which is either an effective address or an arithmetic result, together with the store operand and the load/store type.
- Drives the synchronous data BRAM and holds the EX/MEM pipeline register.
- Produces load-aligned, sign- or zero-extended writeback data one cycle later, plus a forwarding value for the execute stage.

Parameters:
- DADDR_W, 12: word-address width of the data BRAM (BRAM depth 2^DADDR_W words).
- MMIO_BIT, 31: alu_out bit that marks an access as memory-mapped I/O. Such accesses are steered to the io_* ports instead of the BRAM.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute stage holds a live instruction.
- ex_alu_out  in  32  ALU Out: effective address for loads/stores, result otherwise.
- ex_store_data  in  32  rt register value for stores.
- ex_mem_op  in  4  NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8; codes 9-15 treated as NONE.
- ex_rd  in  5  destination register.
- ex_reg_we  in  1  instruction writes a register.
- stall  in  1  hazard/IO stall; freezes this stage.
- dmem_addr  out  DADDR_W  BRAM word address (combinational).
- dmem_we  out  4  BRAM byte write enables.
- dmem_din  out  32  BRAM write data, lane-replicated.
- dmem_dout  in  32  BRAM read data, valid the cycle after the address.
- io_re, io_we  out  1  MMIO strobes, one cycle per access.
- io_addr  out  32  full MMIO address.
- io_dout  in  32  MMIO read data, same timing as dmem_dout.
- wb_valid  out  1  writeback stage instruction is live.
- wb_rd  out  5  registered destination.
- wb_we  out  1  registered register write enable, gated by wb_valid.
- wb_data  out  32  final writeback value.
- fwd_data  out  32  registered ALU result for EX forwarding; not valid for loads.
- misalign  out  1  registered: current wb instruction was a misaligned access.

Behaviour:
- Address path:
  - When stall=0: dmem_addr = ex_alu_out[DADDR_W+1:2].
  - When stall=1: dmem_addr = registered address, so BRAM output stays stable.
- Byte offset and alignment:
  - off = ex_alu_out[1:0].
  - Halfword is misaligned if off[0]=1.
  - Word is misaligned if off!=0.
- Stores, when ex_valid & !stall & store & !MMIO:
  - SB: dmem_we = 4'b0001 << off; dmem_din = {4{byte}}.
  - SH: dmem_we = 4'b0011 << off; dmem_din = {2{half}}.
  - SW: dmem_we = 4'b1111.
  - Lane 0 = bits 7:0 (little-endian lanes).
  - Otherwise dmem_we = 0.
- MMIO (ex_alu_out[MMIO_BIT]=1): io_we/io_re pulse combinationally for one non-stalled cycle; dmem_we = 0.
- Pipeline register, on the posedge when !stall:
  - Captures valid, mem_op, off, rd, reg_we, alu_out, the MMIO flag and the misalign flag.
  - With stall=1 all registers hold.
  - An instruction is never duplicated or dropped.
- Writeback data, combinational from registered state plus the selected dout:
  - LB/LBU: select byte by off; sign- or zero-extend.
  - LH/LHU: select half by off[1]; sign- or zero-extend.
  - LW: word.
  - Non-load: registered alu_out.
- Latency: 1 cycle from EX to wb outputs.
- Reset:
  - wb_valid=0, wb_we=0, misalign=0, wb_rd=0.
  - Pipeline data registers cleared to 0.
  - dmem_we=0 and io strobes=0 while rst=1.
- Reset overrides stall.
- A store presented during reset is not written.
- ex_valid=0 produces a bubble: wb_valid=0 next cycle, no writes or strobes.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned LH/LHU/LW/SH/SW suppresses dmem_we, io_we and io_re.
  - Registers misalign=1 and forces wb_we=0 for that instruction.
- Undefined:
  - The low offset bits are ignored for the access width: halfword uses off[1], word uses 0.
  - The access completes force-aligned; misalign is tied to 0.

Decomposition:
- Shared package/header (alongside Opcode.vh/ALUop.vh): MEMOP_* encodings, MEMOP_W=4, MMIO base constants.
- One natural sub-module: load_align. Purely combinational: (mem_op, off, dout) -> extended wb value.

Test Plan:
- SW 0xDEADBEEF to alu_out=0x10, then LW 0x10 -> dmem_we=4'b1111, addr=4; next-next cycle wb_data=0xDEADBEEF, wb_rd as issued.
- SB 0x80 to 0x13, then LB 0x13 / LBU 0x13 -> dmem_we=4'b1000; wb_data=0xFFFFFF80 then 0x00000080.
- LH 0x12 with memory word 0x8001_7FFF -> wb_data=0xFFFF8001; LHU -> 0x00008001.
- Stall for 3 cycles mid-load -> wb_data, wb_rd and dmem_addr stable; one wb_valid instruction retires after release; no duplicate BRAM write for a stalled SW.
- With MEM_MISALIGN_TRAP_EN, SW to 0x11 -> dmem_we=0, misalign=1, wb_we=0; without the macro -> word written at address 0x10.
- rst asserted with a SW in EX and stall=1 -> no write; wb_valid=0 after the edge; MMIO load to 0x80000008 yields io_re pulse and wb_data=io_dout.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - load/store op encodings and MMIO constants for the memory stage.
package mem_stage_pkg;

  localparam int MEMOP_W = 4;
  localparam int MMIO_BIT_DEFAULT = 31;

  typedef enum logic [MEMOP_W-1:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LH   = 4'd2,
    MEMOP_LW   = 4'd3,
    MEMOP_LBU  = 4'd4,
    MEMOP_LHU  = 4'd5,
    MEMOP_SB   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SW   = 4'd8
  } mem_op_e;

  // Unused encodings 9-15 collapse to NONE so nothing downstream sees them.
  function automatic mem_op_e memop_decode(input logic [MEMOP_W-1:0] raw);
    if (raw > 4'd8) return MEMOP_NONE;
    return mem_op_e'(raw);
  endfunction

  function automatic logic memop_is_load(input mem_op_e op);
    return (op == MEMOP_LB) || (op == MEMOP_LH) || (op == MEMOP_LW) ||
           (op == MEMOP_LBU) || (op == MEMOP_LHU);
  endfunction

  function automatic logic memop_is_store(input mem_op_e op);
    return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  function automatic logic memop_misaligned(input mem_op_e op, input logic [1:0] off);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return off[0];
      MEMOP_LW, MEMOP_SW:            return off != 2'b00;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - selects and extends the loaded byte/half/word.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  mem_op_e     mem_op,
  input  logic [1:0]  off,
  input  logic [31:0] dout,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dout[{off, 3'b000} +: 8];
    half_sel = off[1] ? dout[31:16] : dout[15:0];
    case (mem_op)
      MEMOP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_LBU: data = {24'd0, byte_sel};
      MEMOP_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEMOP_LHU: data = {16'd0, half_sel};
      MEMOP_LW:  data = dout;
      default:   data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS150 memory stage: BRAM/MMIO access and EX/MEM register.
// MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are suppressed and flagged.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DADDR_W  = 12,
  parameter int MMIO_BIT = MMIO_BIT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [31:0]        ex_alu_out,
  input  logic [31:0]        ex_store_data,
  input  logic [3:0]         ex_mem_op,
  input  logic [4:0]         ex_rd,
  input  logic               ex_reg_we,
  input  logic               stall,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [3:0]         dmem_we,
  output logic [31:0]        dmem_din,
  input  logic [31:0]        dmem_dout,
  output logic               io_re,
  output logic               io_we,
  output logic [31:0]        io_addr,
  input  logic [31:0]        io_dout,
  output logic               wb_valid,
  output logic [4:0]         wb_rd,
  output logic               wb_we,
  output logic [31:0]        wb_data,
  output logic [31:0]        fwd_data,
  output logic               misalign
);

  mem_op_e    ex_op;
  logic [1:0] ex_off;
  logic       ex_mmio;
  logic       ex_mis;
  logic       ex_fire;

  assign ex_op   = memop_decode(ex_mem_op);
  assign ex_off  = ex_alu_out[1:0];
  assign ex_mmio = ex_alu_out[MMIO_BIT];
`ifdef MEM_MISALIGN_TRAP_EN
  assign ex_mis  = memop_misaligned(ex_op, ex_off);
`else
  assign ex_mis  = 1'b0;
`endif
  assign ex_fire = ex_valid & ~stall & ~rst & ~ex_mis;

  logic        valid_q, valid_d;
  mem_op_e     op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_we_q, reg_we_d;
  logic [31:0] alu_q, alu_d;
  logic        mmio_q, mmio_d;
  logic        mis_q, mis_d;

  always_comb begin
    dmem_we  = 4'b0000;
    dmem_din = ex_store_data;
    io_we    = 1'b0;
    io_re    = 1'b0;
    case (ex_op)
      MEMOP_SB: dmem_din = {4{ex_store_data[7:0]}};
      MEMOP_SH: dmem_din = {2{ex_store_data[15:0]}};
      default:  ;
    endcase
    if (ex_fire) begin
      if (ex_mmio) begin
        io_we = memop_is_store(ex_op);
        io_re = memop_is_load(ex_op);
      end else begin
        // Halfword lanes come from off[1] only, so an untrapped odd offset lands force-aligned.
        case (ex_op)
          MEMOP_SB: dmem_we = 4'b0001 << ex_off;
          MEMOP_SH: dmem_we = 4'b0011 << {ex_off[1], 1'b0};
          MEMOP_SW: dmem_we = 4'b1111;
          default:  dmem_we = 4'b0000;
        endcase
      end
    end
  end

  // Holding the captured address under stall keeps the BRAM read data steady.
  assign dmem_addr = stall ? alu_q[DADDR_W+1:2] : ex_alu_out[DADDR_W+1:2];
  assign io_addr   = ex_alu_out;

  always_comb begin
    valid_d  = valid_q;
    op_d     = op_q;
    off_d    = off_q;
    rd_d     = rd_q;
    reg_we_d = reg_we_q;
    alu_d    = alu_q;
    mmio_d   = mmio_q;
    mis_d    = mis_q;
    if (!stall) begin
      valid_d  = ex_valid;
      op_d     = ex_op;
      off_d    = ex_off;
      rd_d     = ex_rd;
      reg_we_d = ex_reg_we;
      alu_d    = ex_alu_out;
      mmio_d   = ex_mmio;
      mis_d    = ex_valid & ex_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      op_q     <= MEMOP_NONE;
      off_q    <= 2'd0;
      rd_q     <= 5'd0;
      reg_we_q <= 1'b0;
      alu_q    <= 32'd0;
      mmio_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      op_q     <= op_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      reg_we_q <= reg_we_d;
      alu_q    <= alu_d;
      mmio_q   <= mmio_d;
      mis_q    <= mis_d;
    end
  end

  logic [31:0] ld_data;

  mem_stage_load_align u_load_align (
    .mem_op (op_q),
    .off    (off_q),
    .dout   (mmio_q ? io_dout : dmem_dout),
    .data   (ld_data)
  );

  assign wb_valid = valid_q;
  assign wb_rd    = rd_q;
  assign wb_we    = valid_q & reg_we_q & ~mis_q;
  assign wb_data  = memop_is_load(op_q) ? ld_data : alu_q;
  assign fwd_data = alu_q;
  assign misalign = mis_q;

endmodule
